csa_mp_seq: RTL
===============

Name: csa_mp_seq

Overview:
Multi-precision add/subtract sequencer built around a single csa_16bit carry-select adder instance (ports x, y, cin, sum, cout).
- Accepts WORDS×16-bit operands through a valid/ready handshake.
- Drives the shared 16-bit adder one word per cycle, least-significant word first, chaining the carry.
- Returns the wide result and final carry through a second valid/ready handshake.
- Sits between an operand producer (e.g. a wide-counter or checksum engine) and the adder datapath.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal range 1..16); operand width is WORDS*16.
- CW, $clog2(WORDS)+1, word-index counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- start_valid  input  1  operand request valid.
- start_ready  output  1  block can accept a request; high only in IDLE.
- op_a  input  WORDS*16  operand A.
- op_b  input  WORDS*16  operand B.
- sub  input  1  1 = A−B, 0 = A+B; sampled on accept.
- cin  input  1  carry-in for add; ignored when sub=1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- result  output  WORDS*16  sum/difference, modulo 2^(WORDS*16).
- cout  output  1  final carry-out; for sub, 1 = no borrow (A≥B unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, word index=0, carry register=0, operand registers=0.
  - result=0, cout=0, res_valid=0, busy=0.
  - start_ready goes high the cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready at edge E0:
  - latch op_a;
  - latch op_b, or ~op_b when sub=1;
  - set carry = sub ? 1 : cin;
  - set index = 0 and clear result to 0;
  - go to RUN.
- RUN: the adder is fed combinationally with x=A[16*idx+:16], y=B'[16*idx+:16], cin=carry. At each edge:
  - result[16*idx+:16] <= sum;
  - carry <= adder cout;
  - idx <= idx+1.
  - On the edge that writes word WORDS−1: cout <= adder cout, go to DONE.
- DONE: res_valid=1. result and cout are stable while res_valid=1 && res_ready=0. On res_valid&&res_ready: return to IDLE, res_valid=0.
- Latency:
  - res_valid first high exactly WORDS cycles after the accept edge.
  - Minimum request-to-request spacing is WORDS+2 cycles. There is no accept in the same cycle as result handoff.
- start_valid while not IDLE: ignored (start_ready=0), with no side effect.
- Inputs op_a, op_b, sub, cin are don't-care except at the accept edge. Changes during RUN must not affect the result.
- Wrap-around: all-ones + 1 gives result=0, cout=1. The carry must propagate through all words, one word per cycle.
- WORDS=1: RUN lasts exactly one cycle. Behaviour is identical to a single csa_16bit add, registered.
- Reset mid-RUN or mid-DONE: synchronous reset wins over all other events that cycle. Partial result is discarded (result=0) and the pending result is lost.
- result holds its last value in IDLE until the next accept, which clears it.
- The adder is the only arithmetic resource. No additional '+' operator on data widths ≥16 bits.

Test Plan:
- WORDS=4, add, cin=0, A=25004 (word0), B=60 → after 4 cycles res_valid=1, result=64'd25064, cout=0.
- Add, cin=0, A=64'h0000_0000_0000_FFFF, B=1 → result=64'h0000_0000_0001_0000, cout=0. Confirms the inter-word carry chain.
- Add, cin=1, A=64'hFFFF_FFFF_FFFF_FFFF, B=0 → result=0, cout=1. Also A=43690, B=21845, cin=1 → result=65536, cout=0.
- Sub:
  - A=5, B=7 → result=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
  - A=7, B=5 → result=2, cout=1.
  - cin value ignored in both cases.
- Back-pressure:
  - hold res_ready=0 for 3 cycles in DONE → result/cout unchanged, start_ready=0.
  - start_valid pulses during RUN/DONE are ignored.
  - res_ready=1 → IDLE next cycle, start_ready=1.
- Reset: assert rst_n=0 for one edge at RUN idx=2 → next cycle IDLE, result=0, res_valid=0, busy=0. A following request completes correctly.

Source files
------------

// File: rtl/csa_mp_seq_if.sv
// Request/result bus for the multi-precision add/subtract sequencer.
// master: operand producer / result consumer. slave: the sequencer.
//   start_valid/start_ready  request handshake carrying op_a, op_b, sub, cin
//   res_valid/res_ready      result handshake carrying result, cout
//   busy                     sequencer is in RUN or DONE
interface csa_mp_seq_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = WORDS * 16;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, cin, res_ready,
    input  start_ready, res_valid, result, cout, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, cin, res_ready,
    output start_ready, res_valid, result, cout, busy
  );
endinterface

// File: rtl/csa_mp_seq.sv
// Multi-precision add/subtract sequencer.
// Accepts WORDS x 16-bit operands, pushes them through one shared 16-bit
// carry-select adder one word per cycle (LSW first, carry chained) and
// returns the wide result plus final carry.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    csa_mp_seq_if.slave (request handshake in, result handshake out)

// 16-bit carry-select adder: 4-bit blocks, upper blocks precompute both carries.
module csa_16bit (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  localparam int unsigned NBLK = 4;

  logic [NBLK-1:0][4:0] r0;
  logic [NBLK-1:0][4:0] r1;
  logic [NBLK:0]        c;

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    assign r0[b] = {1'b0, x[4*b +: 4]} + {1'b0, y[4*b +: 4]};
    assign r1[b] = {1'b0, x[4*b +: 4]} + {1'b0, y[4*b +: 4]} + 5'd1;
  end

  // Carry selects which precomputed block result is used.
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int b = 0; b < NBLK; b++) begin
      sum[4*b +: 4] = c[b] ? r1[b][3:0] : r0[b][3:0];
      c[b+1]        = c[b] ? r1[b][4]   : r0[b][4];
    end
    cout = c[NBLK];
  end
endmodule

module csa_mp_seq #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CW    = $clog2(WORDS) + 1
) (
  input logic         clk,
  input logic         rst_n,
  csa_mp_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WORDS-1:0][15:0] a_q;
  logic [WORDS-1:0][15:0] b_q;
  logic [WORDS-1:0][15:0] res_q;
  logic [CW-1:0]          idx_q;
  logic                   carry_q;
  logic                   cout_q;

  logic start_ready_q;
  logic res_valid_q;
  logic busy_q;
  logic start_ready_d;
  logic res_valid_d;
  logic busy_d;

  logic        accept_c;
  logic        step_c;
  logic        last_c;
  logic        handoff_c;
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic [15:0] add_sum;
  logic        add_cout;

  // Handshake and sequencing conditions shared by next-state and datapath.
  assign accept_c  = (state_q == IDLE) && bus.start_valid && start_ready_q;
  assign step_c    = (state_q == RUN);
  assign last_c    = step_c && (idx_q == CW'(WORDS - 1));
  assign handoff_c = (state_q == DONE) && res_valid_q && bus.res_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)  state_d = RUN;
      RUN:     if (last_c)    state_d = DONE;
      DONE:    if (handoff_c) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output decode from the next state so handshake outputs come from flops.
  always_comb begin
    start_ready_d = 1'b0;
    res_valid_d   = 1'b0;
    busy_d        = 1'b0;
    case (state_d)
      IDLE:    start_ready_d = 1'b1;
      RUN:     busy_d        = 1'b1;
      DONE: begin
        res_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      default: start_ready_d = 1'b0;
    endcase
  end

  // Select the current word pair for the shared adder.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (idx_q == CW'(w)) begin
        a_word = a_q[w];
        b_word = b_q[w];
      end
    end
  end

  csa_16bit u_add (
    .x   (a_word),
    .y   (b_word),
    .cin (carry_q),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Operand capture, per-word result write-back and carry chaining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      if (accept_c) begin
        a_q     <= bus.op_a;
        // Subtraction as A + ~B + 1; cin is ignored for sub.
        b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
        carry_q <= bus.sub ? 1'b1 : bus.cin;
        idx_q   <= '0;
        res_q   <= '0;
      end else if (step_c) begin
        for (int w = 0; w < int'(WORDS); w++) begin
          if (idx_q == CW'(w)) begin
            res_q[w] <= add_sum;
          end
        end
        carry_q <= add_cout;
        idx_q   <= idx_q + CW'(1);
        if (last_c) begin
          cout_q <= add_cout;
        end
      end
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.result      = res_q;
  assign bus.cout        = cout_q;
endmodule
